// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data memory controller.
//   - access mode encodings (DM_WORD .. DM_BYTE_U)
//   - controller FSM state encoding
//   - dm_load_extend(): lane select plus sign/zero extension for loads
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'd0;
    localparam logic [2:0] DM_HALF   = 3'd1;
    localparam logic [2:0] DM_HALF_U = 3'd2;
    localparam logic [2:0] DM_BYTE   = 3'd3;
    localparam logic [2:0] DM_BYTE_U = 3'd4;

    typedef enum logic [1:0] {
        DM_IDLE      = 2'd0,
        DM_LOAD_WAIT = 2'd1,
        DM_RESP      = 2'd2
    } dm_state_e;

    // Shift the addressed lane down to bit 0, then extend per mode.
    function automatic logic [31:0] dm_load_extend(input logic [31:0] word,
                                                   input logic [2:0]  mode,
                                                   input logic [1:0]  lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (mode)
            DM_WORD:   return word;
            DM_HALF:   return {{16{sh[15]}}, sh[15:0]};
            DM_HALF_U: return {16'h0000, sh[15:0]};
            DM_BYTE:   return {{24{sh[7]}}, sh[7:0]};
            DM_BYTE_U: return {24'h000000, sh[7:0]};
            default:   return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_ram_bytewe.sv
// dm_ram_bytewe: 2**ADDR_W x 32-bit synchronous RAM, 4 byte lanes.
// Port A: read/write, read-first (a write returns the old word on rdata_a).
// Port B: read-only, present only when DM_DEBUG_PORT_EN is defined;
//         rdata_b is registered and cleared by rst.
// Ports:
//   clk          clock
//   we_a[3:0]    per-lane write enables, port A
//   addr_a       word address, port A
//   wdata_a      write data, port A
//   rdata_a      registered read data, port A
//   rst          reset for rdata_b (DM_DEBUG_PORT_EN only)
//   addr_b       word address, port B (DM_DEBUG_PORT_EN only)
//   rdata_b      registered read data, port B (DM_DEBUG_PORT_EN only)
// Memory contents are never reset.
module dm_ram_bytewe #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [31:0]       wdata_a,
    output logic [31:0]       rdata_a
`ifdef DM_DEBUG_PORT_EN
    ,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [31:0]       rdata_b
`endif
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_a[i]) begin
                mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
            end
        end
        rdata_a <= mem[addr_a];
    end

`ifdef DM_DEBUG_PORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_b <= 32'h0000_0000;
        end else begin
            rdata_b <= mem[addr_b];
        end
    end
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller in front of a byte-lane RAM.
// Accepts one request at a time (valid/ready), checks alignment and range,
// performs byte/half/word stores with lane enables and returns extended
// load data. Store/error responses come 1 cycle after accept, loads 2.
// Optional feature: DM_DEBUG_PORT_EN adds a read-only debug port
// (dbg_addr/dbg_rdata) on the second port of the RAM.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_mode         store flag, access mode (dm_pkg DM_*)
//   req_addr, req_wdata      byte address, right-aligned store data
//   rsp_valid                one-cycle response pulse
//   rsp_rdata, rsp_err       load data, rejection flag (0 outside rsp_valid)
//   err_count                saturating count of rejected requests
//   dbg_addr, dbg_rdata      debug read port (DM_DEBUG_PORT_EN only)
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int BYTE_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_mode,
    input  logic [BYTE_ADDR_W-1:0] req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [15:0]            err_count
`ifdef DM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic [31:0]            dbg_rdata
`endif
);

    dm_state_e state, state_nxt;

    logic [ADDR_W-1:0]      word_idx;
    logic [1:0]             lane;
    logic [BYTE_ADDR_W-1:0] addr_hi;
    logic                   req_bad;
    logic                   accept;
    logic [3:0]             be;
    logic [31:0]            wdata_rep;
    logic [3:0]             ram_we;
    logic [31:0]            ram_rdata;
    logic [2:0]             mode_q;
    logic [1:0]             lane_q;

    assign word_idx = req_addr[ADDR_W+1:2];
    assign lane     = req_addr[1:0];
    assign addr_hi  = req_addr >> (ADDR_W + 2);

    // Holding off ready while rst is high keeps a store that coincides with
    // the reset-release edge from being accepted.
    assign req_ready = (state == DM_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DM_RESP);

    always_comb begin
        req_bad = 1'b0;
        if (req_mode > DM_BYTE_U) begin
            req_bad = 1'b1;
        end
        if (req_mode == DM_WORD && lane != 2'd0) begin
            req_bad = 1'b1;
        end
        if ((req_mode == DM_HALF || req_mode == DM_HALF_U) && lane[0]) begin
            req_bad = 1'b1;
        end
        if (addr_hi != '0) begin
            req_bad = 1'b1;
        end
    end

    // Unsigned modes only matter for loads; stores treat them as signed ones.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_mode)
            DM_WORD: begin
                be        = 4'b1111;
                wdata_rep = req_wdata;
            end
            DM_HALF, DM_HALF_U: begin
                be        = 4'b0011 << lane;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            DM_BYTE, DM_BYTE_U: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = req_wdata;
            end
        endcase
    end

    assign ram_we = (accept && req_we && !req_bad) ? be : 4'b0000;

    dm_ram_bytewe #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_a    (ram_we),
        .addr_a  (word_idx),
        .wdata_a (wdata_rep),
        .rdata_a (ram_rdata)
`ifdef DM_DEBUG_PORT_EN
        ,
        .rst     (rst),
        .addr_b  (dbg_addr),
        .rdata_b (dbg_rdata)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DM_IDLE: begin
                if (accept) begin
                    state_nxt = (req_we || req_bad) ? DM_RESP : DM_LOAD_WAIT;
                end
            end
            DM_LOAD_WAIT: state_nxt = DM_RESP;
            DM_RESP:      state_nxt = DM_IDLE;
            default:      state_nxt = DM_IDLE;
        endcase
    end

    // Response fields are loaded only on the edge entering RESP and cleared
    // on every other edge, so they read 0 whenever rsp_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            mode_q    <= DM_WORD;
            lane_q    <= 2'd0;
            err_count <= 16'h0000;
        end else begin
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            if (accept) begin
                mode_q <= req_mode;
                lane_q <= lane;
                if (req_bad) begin
                    rsp_err <= 1'b1;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
            end
            if (state == DM_LOAD_WAIT) begin
                rsp_rdata <= dm_load_extend(ram_rdata, mode_q, lane_q);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl.
// Inputs are driven away from the rising edge; outputs sampled on the
// falling edge. Define DM_DEBUG_PORT_EN to also exercise the debug port.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_count;
`ifdef DM_DEBUG_PORT_EN
    logic [11:0] dbg_addr;
    logic [31:0] dbg_rdata;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    data_mem_ctrl #(
        .ADDR_W      (12),
        .BYTE_ADDR_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_mode  (req_mode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count)
`ifdef DM_DEBUG_PORT_EN
        ,
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one request and wait for its response. lat = rising edges from
    // accept to the first falling-edge sample showing rsp_valid (0 = none).
    task automatic do_req(input logic we, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        int waits;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!req_ready && waits < 10);
        req_valid = 1'b1;
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 5 && lat == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat   = i;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
`ifdef DM_DEBUG_PORT_EN
        dbg_addr = 12'd0;
`endif
        repeat (3) @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        n_vec++;
        if (err_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_errcnt: got %h want 0000", err_count);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word;
        logic [31:0] d; logic e; int lat;
        do_req(1'b1, 3'd0, 32'h10, 32'hDEADBEEF, d, e, lat);
        n_vec++;
        if (lat !== 1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL st_word: got lat=%0d err=%b want lat=1 err=0", lat, e);
        end
        do_req(1'b0, 3'd0, 32'h10, 32'h0, d, e, lat);
        n_vec++;
        if (lat !== 2 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_word_lat: got lat=%0d err=%b want lat=2 err=0", lat, e);
        end
        n_vec++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ld_word_data: got %h want deadbeef", d);
        end
    endtask

    task automatic test_subword;
        logic [31:0] d; logic e; int lat;
        do_req(1'b1, 3'd3, 32'h12, 32'hFFFFFF5A, d, e, lat);
        n_vec++;
        if (lat !== 1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL st_byte: got lat=%0d err=%b want lat=1 err=0", lat, e);
        end
        do_req(1'b0, 3'd0, 32'h10, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'hDE5ABEEF) begin
            n_fail++;
            $display("FAIL ld_word_after_byte: got %h want de5abeef", d);
        end
        do_req(1'b0, 3'd3, 32'h12, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'h0000005A) begin
            n_fail++;
            $display("FAIL ld_byte_12: got %h want 0000005a", d);
        end
        do_req(1'b0, 3'd1, 32'h12, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'hFFFFDE5A) begin
            n_fail++;
            $display("FAIL ld_half_12: got %h want ffffde5a", d);
        end
        do_req(1'b0, 3'd2, 32'h12, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'h0000DE5A) begin
            n_fail++;
            $display("FAIL ld_halfu_12: got %h want 0000de5a", d);
        end
        do_req(1'b0, 3'd3, 32'h13, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'hFFFFFFDE) begin
            n_fail++;
            $display("FAIL ld_byte_13: got %h want ffffffde", d);
        end
        do_req(1'b0, 3'd4, 32'h13, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'h000000DE) begin
            n_fail++;
            $display("FAIL ld_byteu_13: got %h want 000000de", d);
        end
        // mode 2 store behaves as a half store to lanes 0/1
        do_req(1'b1, 3'd2, 32'h10, 32'hABCD1234, d, e, lat);
        do_req(1'b0, 3'd0, 32'h10, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'hDE5A1234) begin
            n_fail++;
            $display("FAIL st_halfu: got %h want de5a1234", d);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int lat;
        do_req(1'b0, 3'd0, 32'h11, 32'h0, d, e, lat);
        n_vec++;
        if (lat !== 1 || e !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL err_ld_word_11: got lat=%0d err=%b d=%h want 1/1/0", lat, e, d);
        end
        do_req(1'b1, 3'd1, 32'h13, 32'hFFFF7777, d, e, lat);
        n_vec++;
        if (lat !== 1 || e !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL err_st_half_13: got lat=%0d err=%b d=%h want 1/1/0", lat, e, d);
        end
        n_vec++;
        if (err_count !== 16'd2) begin
            n_fail++;
            $display("FAIL err_count_2: got %0d want 2", err_count);
        end
        do_req(1'b0, 3'd5, 32'h10, 32'h0, d, e, lat);
        n_vec++;
        if (e !== 1'b1 || err_count !== 16'd3) begin
            n_fail++;
            $display("FAIL err_mode5: got err=%b cnt=%0d want 1/3", e, err_count);
        end
        // would alias word 4 if high address bits were ignored
        do_req(1'b1, 3'd0, 32'h00004010, 32'h11111111, d, e, lat);
        n_vec++;
        if (e !== 1'b1 || err_count !== 16'd4) begin
            n_fail++;
            $display("FAIL err_range: got err=%b cnt=%0d want 1/4", e, err_count);
        end
        do_req(1'b0, 3'd0, 32'h10, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'hDE5A1234 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_write: got %h err=%b want de5a1234 err=0", d, e);
        end
    endtask

    task automatic test_back_to_back;
        int n_acc = 0;
        int n_rsp = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'd0;
        req_addr = 32'h10; req_wdata = 32'h0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== (i % 3 == 0) || rsp_valid !== (i % 3 == 2)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got rdy=%b v=%b want rdy=%b v=%b",
                         i, req_ready, rsp_valid, (i % 3 == 0), (i % 3 == 2));
            end
            if (req_valid && req_ready) n_acc++;
            if (rsp_valid) begin
                n_rsp++;
                n_vec++;
                if (rsp_rdata !== 32'hDE5A1234) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h want de5a1234", i, rsp_rdata);
                end
            end
        end
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        n_vec++;
        if (n_acc !== 3 || n_rsp !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3/3", n_acc, n_rsp);
        end
    endtask

    task automatic test_reset_in_load;
        logic [31:0] d; logic e; int lat;
        int waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!req_ready && waits < 10);
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'd0; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_load_in_reset: got v=%b want 0", rsp_valid);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || err_count !== 16'h0) begin
                n_fail++;
                $display("FAIL rst_load_after%0d: got v=%b rdy=%b cnt=%0d want 0/1/0",
                         i, rsp_valid, req_ready, err_count);
            end
        end
        do_req(1'b0, 3'd0, 32'h10, 32'h0, d, e, lat);
        n_vec++;
        if (d !== 32'hDE5A1234 || lat !== 2) begin
            n_fail++;
            $display("FAIL rst_mem_kept: got %h lat=%0d want de5a1234 lat=2", d, lat);
        end
    endtask

`ifdef DM_DEBUG_PORT_EN
    task automatic test_debug_port;
        logic [31:0] d; logic e; int lat;
        int waits = 0;
        do_req(1'b1, 3'd0, 32'h14, 32'hAAAA5555, d, e, lat);
        dbg_addr = 12'd5;
        do begin
            @(negedge clk);
            waits++;
        end while (!req_ready && waits < 10);
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'd0;
        req_addr = 32'h14; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dbg_rdata !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL dbg_old: got %h want aaaa5555", dbg_rdata);
        end
        @(negedge clk);
        n_vec++;
        if (dbg_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL dbg_new: got %h want 12345678", dbg_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_in_load();
`ifdef DM_DEBUG_PORT_EN
        test_debug_port();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
